box_top: RTL and testbench



---
 rtl/box_top.sv | 71 +++++++
 tb/tb_box_top.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/box_top.sv
// Lab fabric top: a debounced active-low push button toggles an LED pattern between
// a binary up-count and a one-hot rotate, both advancing on a prescaled tick.
module box_top #(
    parameter int unsigned DEBOUNCE_CYCLES = 1000,
    parameter int unsigned TICK_DIV        = 5000,
    parameter int unsigned LED_W           = 8
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             PB_SW,
    output logic [LED_W-1:0] LED
);

    localparam int unsigned DB_W  = $clog2(DEBOUNCE_CYCLES);
    localparam int unsigned DIV_W = $clog2(TICK_DIV);
    localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);

    logic             r_sync1;
    logic             r_sync2;
    logic             r_db;
    logic             r_db_prev;
    logic             r_mode;
    logic [DB_W-1:0]  r_db_cnt;
    logic [DIV_W-1:0] r_presc;
    logic [LED_W-1:0] r_led;
    logic             w_press;
    logic             w_tick;

    // Press is the debounced 1->0 transition; releases are ignored.
    assign w_press = r_db_prev & ~r_db;
    assign w_tick  = (r_presc == DIV_LAST);
    assign LED     = r_led;

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_sync1   <= 1'b1;
            r_sync2   <= 1'b1;
            r_db      <= 1'b1;
            r_db_prev <= 1'b1;
            r_db_cnt  <= '0;
            r_presc   <= '0;
            r_mode    <= 1'b0;
            r_led     <= '0;
        end else begin
            r_sync1   <= PB_SW;
            r_sync2   <= r_sync1;
            r_db_prev <= r_db;

            if (r_sync2 == r_db) begin
                r_db_cnt <= '0;
            end else if (r_db_cnt == DB_LAST) begin
                r_db     <= r_sync2;
                r_db_cnt <= '0;
            end else begin
                r_db_cnt <= r_db_cnt + DB_W'(1);
            end

            r_presc <= w_tick ? '0 : r_presc + DIV_W'(1);

            // A press overrides a coincident tick.
            if (w_press) begin
                r_mode <= ~r_mode;
                r_led  <= r_mode ? '0 : LED_W'(1);
            end else if (w_tick) begin
                r_led <= r_mode ? {r_led[LED_W-2:0], r_led[LED_W-1]} : r_led + LED_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_box_top.sv
// Bench for box_top: window-based reference model of debounce, tick and LED modes,
// driven by directed and randomized push-button activity.
module tb_box_top;

    localparam int D    = 4;
    localparam int T    = 10;
    localparam int MAXE = 20000;

    logic       CLK   = 1'b0;
    logic       RST   = 1'b1;
    logic       PB_SW = 1'b1;
    logic [7:0] LED;

    int n_tests = 0;
    int n_fail  = 0;

    // Per-edge history: reset flag, raw button sample, level seen by the debouncer.
    bit rst_at  [0:MAXE];
    bit pb_at   [0:MAXE];
    bit seen_at [0:MAXE];

    int         n_edge       = 0;
    int         m_rst_edge   = 0;
    bit         m_db         = 1'b1;
    bit         m_press_next = 1'b0;
    bit         m_mode       = 1'b0;
    logic [7:0] m_led        = 8'h00;

    box_top #(
        .DEBOUNCE_CYCLES(D),
        .TICK_DIV       (T),
        .LED_W          (8)
    ) dut (
        .CLK  (CLK),
        .RST  (RST),
        .PB_SW(PB_SW),
        .LED  (LED)
    );

    always #5 CLK = ~CLK;

    // Advance the model by one edge using the current inputs, then let the DUT clock.
    task automatic clk_step();
        int e;
        bit press;
        bit flip;
        bit seen;
        e = n_edge + 1;
        if (e > MAXE) begin
            n_fail++;
            $display("FAIL edge_budget: edge=%0d limit=%0d", e, MAXE);
            $fatal(1, "edge budget exceeded");
        end
        rst_at[e] = RST;
        pb_at[e]  = PB_SW;
        if (RST) begin
            m_led        = 8'h00;
            m_mode       = 1'b0;
            m_db         = 1'b1;
            m_press_next = 1'b0;
            m_rst_edge   = e;
        end else begin
            press        = m_press_next;
            m_press_next = 1'b0;
            seen = (e < 2 || rst_at[e-1] || rst_at[e-2]) ? 1'b1 : pb_at[e-2];
            seen_at[e] = seen;
            // Flip once the last D seen levels, all after reset, differ from the debounced level.
            flip = (e - D + 1 > m_rst_edge);
            for (int j = e - D + 1; j <= e; j++) begin
                if (j > 0 && seen_at[j] == m_db) flip = 1'b0;
            end
            if (flip) begin
                if (m_db) m_press_next = 1'b1;
                m_db = !m_db;
            end
            if (press) begin
                m_mode = !m_mode;
                m_led  = m_mode ? 8'h01 : 8'h00;
            end else if ((e - m_rst_edge) % T == 0) begin
                m_led = m_mode ? {m_led[6:0], m_led[7]} : m_led + 8'd1;
            end
        end
        n_edge = e;
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        RST   = 1'b1;
        PB_SW = 1'b1;
        for (int i = 0; i < 3; i++) clk_step();
        n_tests++;
        if (LED !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_led: LED=%h expected 00", LED);
        end
        RST = 1'b0;
    endtask

    task automatic test_count();
        for (int i = 1; i <= 2560; i++) begin
            clk_step();
            n_tests++;
            if (LED !== m_led) begin
                n_fail++;
                $display("FAIL count_seq edge %0d: LED=%h expected %h", n_edge, LED, m_led);
            end
            if (i == 30) begin
                n_tests++;
                if (LED !== 8'h03) begin
                    n_fail++;
                    $display("FAIL count_30: LED=%h expected 03", LED);
                end
            end
            if (i == 2560) begin
                n_tests++;
                if (LED !== 8'h00) begin
                    n_fail++;
                    $display("FAIL count_wrap: LED=%h expected 00", LED);
                end
            end
        end
    endtask

    task automatic test_press_rotate();
        PB_SW = 1'b0;
        for (int i = 1; i <= 50; i++) begin
            clk_step();
            n_tests++;
            if (LED !== m_led) begin
                n_fail++;
                $display("FAIL press_hold edge %0d: LED=%h expected %h", n_edge, LED, m_led);
            end
            if (i == 7) begin
                n_tests++;
                if (LED !== 8'h01) begin
                    n_fail++;
                    $display("FAIL press_latency: LED=%h expected 01", LED);
                end
            end
        end
        PB_SW = 1'b1;
        for (int i = 1; i <= 100; i++) begin
            clk_step();
            n_tests++;
            if (LED !== m_led || $countones(LED) != 1) begin
                n_fail++;
                $display("FAIL rotate_seq edge %0d: LED=%h expected %h", n_edge, LED, m_led);
            end
        end
    endtask

    task automatic test_glitch();
        int hi_len;
        for (int g = 0; g < 5; g++) begin
            PB_SW  = 1'b0;
            hi_len = 3 + int'($urandom_range(4, 9));
            for (int i = 0; i < hi_len; i++) begin
                if (i == 3) PB_SW = 1'b1;
                clk_step();
                n_tests++;
                if (LED !== m_led || $countones(LED) != 1) begin
                    n_fail++;
                    $display("FAIL glitch edge %0d: LED=%h expected %h", n_edge, LED, m_led);
                end
            end
        end
    endtask

    task automatic test_second_press();
        PB_SW = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            clk_step();
            n_tests++;
            if (LED !== m_led) begin
                n_fail++;
                $display("FAIL press2 edge %0d: LED=%h expected %h", n_edge, LED, m_led);
            end
            if (i == 7) begin
                n_tests++;
                if (LED !== 8'h00) begin
                    n_fail++;
                    $display("FAIL press2_count: LED=%h expected 00", LED);
                end
            end
        end
        PB_SW = 1'b1;
        for (int i = 1; i <= 30; i++) begin
            clk_step();
            n_tests++;
            if (LED !== m_led) begin
                n_fail++;
                $display("FAIL press2_inc edge %0d: LED=%h expected %h", n_edge, LED, m_led);
            end
        end
    endtask

    task automatic test_press_on_tick();
        for (int i = 0; i < T && ((n_edge + 7 - m_rst_edge) % T != 0); i++) clk_step();
        PB_SW = 1'b0;
        for (int i = 1; i <= 7; i++) clk_step();
        n_tests++;
        if (LED !== 8'h01) begin
            n_fail++;
            $display("FAIL press_on_tick: LED=%h expected 01", LED);
        end
        PB_SW = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            clk_step();
            n_tests++;
            if (LED !== m_led) begin
                n_fail++;
                $display("FAIL post_tick_press edge %0d: LED=%h expected %h", n_edge, LED, m_led);
            end
        end
    endtask

    task automatic test_reset_mid();
        bit found;
        found = 1'b0;
        for (int i = 0; i < 200 && !found; i++) begin
            clk_step();
            n_tests++;
            if (LED !== m_led) begin
                n_fail++;
                $display("FAIL pre_reset edge %0d: LED=%h expected %h", n_edge, LED, m_led);
            end
            if (m_led == 8'h10) found = 1'b1;
        end
        n_tests++;
        if (!found) begin
            n_fail++;
            $display("FAIL reach_10: LED=%h expected 10 within 200 clks", LED);
        end
        RST = 1'b1;
        clk_step();
        RST = 1'b0;
        n_tests++;
        if (LED !== 8'h00) begin
            n_fail++;
            $display("FAIL mid_reset: LED=%h expected 00", LED);
        end
        for (int i = 1; i <= 30; i++) begin
            clk_step();
            if (i == 9 || i == 10 || i == 30) begin
                n_tests++;
                if (LED !== (i == 9 ? 8'h00 : (i == 10 ? 8'h01 : 8'h03))) begin
                    n_fail++;
                    $display("FAIL after_reset clk %0d: LED=%h expected %h", i, LED,
                             (i == 9 ? 8'h00 : (i == 10 ? 8'h01 : 8'h03)));
                end
            end
        end
    endtask

    task automatic test_reset_held_pb();
        PB_SW = 1'b0;
        RST   = 1'b1;
        clk_step();
        clk_step();
        RST = 1'b0;
        for (int i = 1; i <= 40; i++) begin
            clk_step();
            n_tests++;
            if (LED !== m_led) begin
                n_fail++;
                $display("FAIL held_pb edge %0d: LED=%h expected %h", n_edge, LED, m_led);
            end
            if (i == 7) begin
                n_tests++;
                if (LED !== 8'h01) begin
                    n_fail++;
                    $display("FAIL held_pb_event: LED=%h expected 01", LED);
                end
            end
        end
        PB_SW = 1'b1;
        for (int i = 1; i <= 20; i++) clk_step();
    endtask

    task automatic test_random();
        int len;
        for (int s = 0; s < 150; s++) begin
            PB_SW = 1'($urandom_range(0, 1));
            RST   = ($urandom_range(0, 39) == 0);
            len   = int'($urandom_range(1, 12));
            for (int i = 0; i < len; i++) begin
                clk_step();
                RST = 1'b0;
                n_tests++;
                if (LED !== m_led) begin
                    n_fail++;
                    $display("FAIL random edge %0d: LED=%h expected %h", n_edge, LED, m_led);
                end
            end
        end
    endtask

    initial begin
        rst_at[0]  = 1'b1;
        pb_at[0]   = 1'b1;
        seen_at[0] = 1'b1;
        test_reset();
        test_count();
        test_press_rotate();
        test_glitch();
        test_second_press();
        test_press_on_tick();
        test_reset_mid();
        test_reset_held_pb();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
